code_cpu: RTL and testbench
===========================

# code_cpu

Execution core for the three-address code machine. It accepts program and data words on a memory-load port, then runs the loaded program from instruction 0 until END. It reports the last arithmetic result and an error flag with a RDY handshake. It is the design-under-test driven by the SM_TB stimulus generator: it consumes the load stream that SM_TB produces and drives its RDY/ERROR/RESULT inputs.

## Interface
- ADDR_WIDTH, 7: load address width; MSB selects memory, low 6 bits are the word address.
- DATA_WIDTH, 21: load data / instruction width (3 opcode + 3×6 operand addresses).
- RESULT_WIDTH, 16: data word and result width, two's complement.
- RDY_CYCLES, 4: cycles RDY stays high per completed program (≥1).
- i_CLK  in  1  clock; all state updates on rising edge.
- i_RSTn  in  1  reset, asynchronous, active-low.
- i_WE  in  1  load strobe.
- i_ADDRESS  in  ADDR_WIDTH  bit6=0: instruction memory; bit6=1: data memory; [5:0] word address.
- i_DATA  in  DATA_WIDTH  instruction {op[20:18], A[17:12], B[11:6], D[5:0]}, or data in [15:0] with [20:16] ignored.
- o_RDY  out  1  program finished; RESULT/ERROR valid.
- o_ERROR  out  1  execution error.
- o_RESULT  out  RESULT_WIDTH  value written by the last executed arithmetic instruction.

## Operation
- Memories: IMEM 64×21, DMEM 64×16, both register arrays cleared by reset only. Contents persist across programs.
- Opcodes: NOP=000, ADD=001, SUB=010, MUL=011, END=111. Other codes are illegal.
- Semantics: DMEM[D] = DMEM[A] op DMEM[B], signed 16-bit. SUB is A−B. D may equal A or B; operands are read before the write.
- Overflow: the ADD/SUB 17-bit result, or the MUL 32-bit product, does not fit signed 16 bits → error. The write is suppressed and o_RESULT is unchanged.
- An illegal opcode → error.
- PC reaching 63 on a non-END instruction: execute it, then error (missing END).
- States:
  - LOAD: writes accepted when i_WE=1. A registered falling edge of i_WE (we_d=1, i_WE=0) → FETCH, PC=0, o_ERROR=0, o_RESULT kept.
  - FETCH: IR ← IMEM[PC] → EXEC.
  - EXEC: decode.
    - END → DONE.
    - Error → DONE with o_ERROR=1.
    - Otherwise write the result (for arithmetic ops), o_RESULT ← result, PC++ → FETCH.
  - DONE: o_RDY=1 for RDY_CYCLES cycles, then o_RDY=0 → LOAD.
- i_WE outside LOAD is ignored and writes nothing. A falling i_WE outside LOAD does not restart execution.

## Timing
- Reset (any time, including mid-execution): state LOAD, PC=0, we_d=0, o_RDY=0, o_ERROR=0, o_RESULT=0, all memory words 0.
- Load write: i_ADDRESS/i_DATA/i_WE sampled at the rising edge; the data is visible one cycle later.
- Start: first FETCH in the cycle after the edge that samples i_WE=0 with we_d=1.
- Each instruction takes 2 cycles (FETCH+EXEC). A program of N instructions including END reaches DONE 2N cycles after start. o_RDY rises on that same edge, with o_RESULT/o_ERROR already final.
- o_RESULT and o_ERROR are held through DONE and LOAD until the next start clears o_ERROR.
- A DMEM write in EXEC and an operand read of the same address in the next instruction: the new value is seen (write lands before the next EXEC).

## Structure
- Package code_pkg: opcode constants, widths (OP_COD_WIDTH=3, OP_ADDR_WIDTH=6), state enum {LOAD, FETCH, EXEC, DONE}, instruction struct typedef.
- Sub-module code_regfile: 64×16 DMEM with two asynchronous read ports and one synchronous write port. The write port is muxed between the load path and the EXEC path.
- IMEM, FSM, ALU and overflow logic stay in code_cpu.

## Test plan
- Load DAT 1=5, DAT 2=7, ADD 1 2 3, END, drop i_WE → o_RDY after 4 cycles, o_RESULT=12, o_ERROR=0, DMEM[3]=12.
- DAT 1=100, DAT 2=−3, MUL 1 2 4, SUB 4 1 5, END → o_RESULT=−400, DMEM[5]=−400, o_ERROR=0.
- DAT 1=32767, DAT 2=1, ADD 1 2 3, END → o_ERROR=1, o_RESULT keeps its prior value, DMEM[3] unchanged, o_RDY high exactly RDY_CYCLES cycles.
- IMEM[0] opcode 101 → o_ERROR=1 two cycles after start. The next program loads and runs normally with o_ERROR cleared at its start.
- Assert i_RSTn low during EXEC of a 10-instruction program → all outputs 0 immediately; a reload then yields the correct result.
- i_WE pulses during FETCH/EXEC/DONE → no IMEM/DMEM change and no restart. 63 NOPs without END → o_ERROR=1 after 128 cycles.

Source files
------------

// File: rtl/code_pkg.sv
// Shared definitions for the three-address code machine: widths, opcodes,
// FSM state encoding and the instruction word layout.
package code_pkg;

    localparam int unsigned OP_COD_WIDTH  = 3;
    localparam int unsigned OP_ADDR_WIDTH = 6;
    localparam int unsigned MEM_DEPTH     = 1 << OP_ADDR_WIDTH;
    localparam int unsigned WORD_WIDTH    = 16;

    localparam logic [OP_COD_WIDTH-1:0] OP_NOP = 3'b000;
    localparam logic [OP_COD_WIDTH-1:0] OP_ADD = 3'b001;
    localparam logic [OP_COD_WIDTH-1:0] OP_SUB = 3'b010;
    localparam logic [OP_COD_WIDTH-1:0] OP_MUL = 3'b011;
    localparam logic [OP_COD_WIDTH-1:0] OP_END = 3'b111;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // {op, A, B, D}: DMEM[D] = DMEM[A] op DMEM[B]
    typedef struct packed {
        logic [OP_COD_WIDTH-1:0]  op;
        logic [OP_ADDR_WIDTH-1:0] a;
        logic [OP_ADDR_WIDTH-1:0] b;
        logic [OP_ADDR_WIDTH-1:0] d;
    } instr_t;

endpackage

// File: rtl/code_regfile.sv
// Data memory: register array with two asynchronous read ports and one
// synchronous write port, cleared only by reset.
//   i_CLK, i_RSTn          clock, async active-low reset
//   i_we, i_waddr, i_wdata write port
//   i_raddr_a/b            read addresses
//   o_rdata_a/b            combinational read data
module code_regfile #(
    parameter int unsigned AW = 6,
    parameter int unsigned DW = 16
) (
    input  logic          i_CLK,
    input  logic          i_RSTn,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr_a,
    input  logic [AW-1:0] i_raddr_b,
    output logic [DW-1:0] o_rdata_a,
    output logic [DW-1:0] o_rdata_b
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/code_cpu.sv
// Execution core for the three-address code machine. Program/data words are
// loaded while idle; a falling load strobe starts execution at instruction 0.
//   i_CLK, i_RSTn  clock, async active-low reset
//   i_WE           load strobe (honoured only while idle)
//   i_ADDRESS      [6]=0 IMEM, [6]=1 DMEM; [5:0] word address
//   i_DATA         instruction word, or data word in [15:0]
//   o_RDY          program finished, held for RDY_CYCLES cycles
//   o_ERROR        overflow, illegal opcode or missing END
//   o_RESULT       value written by the last executed arithmetic instruction
module code_cpu
    import code_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 7,
    parameter int unsigned DATA_WIDTH   = 21,
    parameter int unsigned RESULT_WIDTH = 16,
    parameter int unsigned RDY_CYCLES   = 4
) (
    input  logic                    i_CLK,
    input  logic                    i_RSTn,
    input  logic                    i_WE,
    input  logic [ADDR_WIDTH-1:0]   i_ADDRESS,
    input  logic [DATA_WIDTH-1:0]   i_DATA,
    output logic                    o_RDY,
    output logic                    o_ERROR,
    output logic [RESULT_WIDTH-1:0] o_RESULT
);

    localparam int unsigned CNT_W = (RDY_CYCLES > 1) ? $clog2(RDY_CYCLES) : 1;
    localparam logic [OP_ADDR_WIDTH-1:0] PC_LAST = OP_ADDR_WIDTH'(MEM_DEPTH - 1);

    state_e                    r_state, w_state_nxt;
    logic [OP_ADDR_WIDTH-1:0]  r_pc, w_pc_nxt;
    instr_t                    r_ir, w_ir_nxt;
    logic                      r_we_d, w_we_d_nxt;
    logic                      r_rdy, w_rdy_nxt;
    logic                      r_err, w_err_nxt;
    logic [RESULT_WIDTH-1:0]   r_result, w_result_nxt;
    logic [CNT_W-1:0]          r_cnt, w_cnt_nxt;

    logic [DATA_WIDTH-1:0]     r_imem [MEM_DEPTH];
    logic                      w_im_we;

    logic                      w_dm_we;
    logic [OP_ADDR_WIDTH-1:0]  w_dm_waddr;
    logic [RESULT_WIDTH-1:0]   w_dm_wdata;
    logic [RESULT_WIDTH-1:0]   w_rd_a, w_rd_b;

    logic signed [RESULT_WIDTH-1:0] w_a, w_b;
    logic signed [RESULT_WIDTH:0]   w_sum, w_dif;
    logic signed [2*RESULT_WIDTH-1:0] w_prod;
    logic [RESULT_WIDTH-1:0]   w_alu_res;
    logic                      w_ovf;
    logic                      w_is_arith, w_illegal;

    code_regfile #(
        .AW (OP_ADDR_WIDTH),
        .DW (RESULT_WIDTH)
    ) u_dmem (
        .i_CLK     (i_CLK),
        .i_RSTn    (i_RSTn),
        .i_we      (w_dm_we),
        .i_waddr   (w_dm_waddr),
        .i_wdata   (w_dm_wdata),
        .i_raddr_a (r_ir.a),
        .i_raddr_b (r_ir.b),
        .o_rdata_a (w_rd_a),
        .o_rdata_b (w_rd_b)
    );

    // Signed ALU with full-width intermediates for overflow detection
    assign w_a    = w_rd_a;
    assign w_b    = w_rd_b;
    assign w_sum  = (RESULT_WIDTH+1)'(w_a) + (RESULT_WIDTH+1)'(w_b);
    assign w_dif  = (RESULT_WIDTH+1)'(w_a) - (RESULT_WIDTH+1)'(w_b);
    assign w_prod = (2*RESULT_WIDTH)'(w_a) * (2*RESULT_WIDTH)'(w_b);

    assign w_is_arith = (r_ir.op == OP_ADD) || (r_ir.op == OP_SUB) || (r_ir.op == OP_MUL);
    assign w_illegal  = !(w_is_arith || (r_ir.op == OP_NOP) || (r_ir.op == OP_END));

    // Result fits when all bits above the sign bit replicate it
    always_comb begin
        w_alu_res = '0;
        w_ovf     = 1'b0;
        case (r_ir.op)
            OP_ADD: begin
                w_alu_res = w_sum[RESULT_WIDTH-1:0];
                w_ovf     = w_sum[RESULT_WIDTH] ^ w_sum[RESULT_WIDTH-1];
            end
            OP_SUB: begin
                w_alu_res = w_dif[RESULT_WIDTH-1:0];
                w_ovf     = w_dif[RESULT_WIDTH] ^ w_dif[RESULT_WIDTH-1];
            end
            OP_MUL: begin
                w_alu_res = w_prod[RESULT_WIDTH-1:0];
                w_ovf     = !((&w_prod[2*RESULT_WIDTH-1:RESULT_WIDTH-1]) ||
                              !(|w_prod[2*RESULT_WIDTH-1:RESULT_WIDTH-1]));
            end
            default: begin
                w_alu_res = '0;
                w_ovf     = 1'b0;
            end
        endcase
    end

    // Instruction memory
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_imem[i] <= '0;
            end
        end else if (w_im_we) begin
            r_imem[i_ADDRESS[OP_ADDR_WIDTH-1:0]] <= i_DATA;
        end
    end

    // FSM and datapath registers
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            r_state  <= S_LOAD;
            r_pc     <= '0;
            r_ir     <= '0;
            r_we_d   <= 1'b0;
            r_rdy    <= 1'b0;
            r_err    <= 1'b0;
            r_result <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_ir     <= w_ir_nxt;
            r_we_d   <= w_we_d_nxt;
            r_rdy    <= w_rdy_nxt;
            r_err    <= w_err_nxt;
            r_result <= w_result_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    // Next-state, load decode and EXEC write-back
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_ir_nxt     = r_ir;
        w_we_d_nxt   = 1'b0;
        w_rdy_nxt    = r_rdy;
        w_err_nxt    = r_err;
        w_result_nxt = r_result;
        w_cnt_nxt    = r_cnt;
        w_im_we      = 1'b0;
        w_dm_we      = 1'b0;
        w_dm_waddr   = i_ADDRESS[OP_ADDR_WIDTH-1:0];
        w_dm_wdata   = i_DATA[RESULT_WIDTH-1:0];

        case (r_state)
            S_LOAD: begin
                // Strobe history is only tracked while idle, so a pulse
                // that ends during execution can never trigger a start
                w_we_d_nxt = i_WE;
                if (i_WE) begin
                    w_dm_we = i_ADDRESS[ADDR_WIDTH-1];
                    w_im_we = !i_ADDRESS[ADDR_WIDTH-1];
                end
                if (r_we_d && !i_WE) begin
                    w_state_nxt = S_FETCH;
                    w_pc_nxt    = '0;
                    w_err_nxt   = 1'b0;
                end
            end

            S_FETCH: begin
                w_ir_nxt    = instr_t'(r_imem[r_pc]);
                w_state_nxt = S_EXEC;
            end

            S_EXEC: begin
                if (r_ir.op == OP_END) begin
                    w_state_nxt = S_DONE;
                    w_rdy_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                end else if (w_illegal || (w_is_arith && w_ovf)) begin
                    w_state_nxt = S_DONE;
                    w_err_nxt   = 1'b1;
                    w_rdy_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                end else begin
                    if (w_is_arith) begin
                        w_dm_we      = 1'b1;
                        w_dm_waddr   = r_ir.d;
                        w_dm_wdata   = w_alu_res;
                        w_result_nxt = w_alu_res;
                    end
                    // Last slot executed without END: flag missing END
                    if (r_pc == PC_LAST) begin
                        w_state_nxt = S_DONE;
                        w_err_nxt   = 1'b1;
                        w_rdy_nxt   = 1'b1;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_pc_nxt    = r_pc + OP_ADDR_WIDTH'(1);
                        w_state_nxt = S_FETCH;
                    end
                end
            end

            S_DONE: begin
                if (r_cnt == CNT_W'(RDY_CYCLES - 1)) begin
                    w_rdy_nxt   = 1'b0;
                    w_state_nxt = S_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            default: w_state_nxt = S_LOAD;
        endcase
    end

    assign o_RDY    = r_rdy;
    assign o_ERROR  = r_err;
    assign o_RESULT = r_result;

endmodule

// File: tb/tb_code_cpu.sv
// Self-checking bench for code_cpu: directed scenarios plus randomized
// programs, all checked against an instruction-level reference model.
module tb_code_cpu;

    localparam int RDY_CYCLES = 4;
    localparam int OPC_NOP = 0, OPC_ADD = 1, OPC_SUB = 2, OPC_MUL = 3, OPC_END = 7;

    logic        i_CLK = 1'b0;
    logic        i_RSTn = 1'b0;
    logic        i_WE = 1'b0;
    logic [6:0]  i_ADDRESS = '0;
    logic [20:0] i_DATA = '0;
    logic        o_RDY;
    logic        o_ERROR;
    logic [15:0] o_RESULT;

    int n_vec = 0;
    int n_bad = 0;

    // Reference machine state
    int m_imem [64];
    int m_dmem [64];
    int m_result;

    code_cpu #(
        .ADDR_WIDTH   (7),
        .DATA_WIDTH   (21),
        .RESULT_WIDTH (16),
        .RDY_CYCLES   (RDY_CYCLES)
    ) dut (
        .i_CLK     (i_CLK),
        .i_RSTn    (i_RSTn),
        .i_WE      (i_WE),
        .i_ADDRESS (i_ADDRESS),
        .i_DATA    (i_DATA),
        .o_RDY     (o_RDY),
        .o_ERROR   (o_ERROR),
        .o_RESULT  (o_RESULT)
    );

    always #5 i_CLK = ~i_CLK;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int s16(input int v);
        int t;
        t = v & 32'h0000_FFFF;
        return (t > 32767) ? t - 65536 : t;
    endfunction

    function automatic int ins(input int op, input int a, input int b, input int d);
        return (op << 18) | (a << 12) | (b << 6) | d;
    endfunction

    function automatic int rnd_val();
        if ($urandom_range(0, 3) == 0) return s16(int'($urandom));
        return int'($urandom_range(0, 200)) - 100;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_imem[i] = 0;
            m_dmem[i] = 0;
        end
        m_result = 0;
    endtask

    // Run the loaded program on the model: returns cycle count and error
    task automatic model_run(output int cyc, output int err);
        int pc, n, w, op, a, b, d, r;
        pc  = 0;
        n   = 0;
        err = 0;
        while (1) begin
            w  = m_imem[pc];
            op = (w >> 18) & 7;
            a  = (w >> 12) & 63;
            b  = (w >> 6) & 63;
            d  = w & 63;
            n++;
            if (op == OPC_END) break;
            if (op == OPC_ADD || op == OPC_SUB || op == OPC_MUL) begin
                r = (op == OPC_ADD) ? m_dmem[a] + m_dmem[b] :
                    (op == OPC_SUB) ? m_dmem[a] - m_dmem[b] : m_dmem[a] * m_dmem[b];
                if (r > 32767 || r < -32768) begin
                    err = 1;
                    break;
                end
                m_dmem[d] = r;
                m_result  = r;
            end else if (op != OPC_NOP) begin
                err = 1;
                break;
            end
            if (pc == 63) begin
                err = 1;
                break;
            end
            pc++;
        end
        cyc = 2 * n;
    endtask

    task automatic load_word(input bit isdata, input int addr, input int val);
        @(negedge i_CLK);
        i_WE      = 1'b1;
        i_ADDRESS = {isdata, 6'(addr)};
        i_DATA    = 21'(val);
        @(posedge i_CLK);
        if (isdata) m_dmem[addr] = s16(val);
        else        m_imem[addr] = val & 32'h001F_FFFF;
    endtask

    // Drop the strobe, then time the run; with noise, random strobes hit
    // both memories while the core is busy and must be ignored
    task automatic run_check(input string tag, input bit noise);
        int ecyc, eerr, cyc, hi, k;
        bit seen;
        model_run(ecyc, eerr);
        @(negedge i_CLK);
        i_WE = 1'b0;
        @(posedge i_CLK);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 300) begin
            if (noise) begin
                @(negedge i_CLK);
                i_WE      = 1'($urandom_range(0, 1));
                i_ADDRESS = 7'($urandom);
                i_DATA    = {3'b111, 18'($urandom)};
            end
            @(posedge i_CLK);
            #1;
            cyc++;
            seen = o_RDY;
        end
        check({tag, ".cycles"}, seen ? cyc : -1, ecyc);
        check({tag, ".result"}, int'($signed(o_RESULT)), m_result);
        check({tag, ".error"}, int'(o_ERROR), eerr);
        hi = seen ? 1 : 0;
        k  = 0;
        while (o_RDY && hi < 20) begin
            @(negedge i_CLK);
            i_WE      = (noise && k < 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            i_ADDRESS = 7'($urandom);
            i_DATA    = {3'b111, 18'($urandom)};
            k++;
            @(posedge i_CLK);
            #1;
            if (o_RDY) hi++;
        end
        @(negedge i_CLK);
        i_WE = 1'b0;
        check({tag, ".rdy_len"}, hi, RDY_CYCLES);
        check({tag, ".result_held"}, int'($signed(o_RESULT)), m_result);
        check({tag, ".error_held"}, int'(o_ERROR), eerr);
    endtask

    // Observe DMEM[addr] through o_RESULT (DMEM[0] is added)
    task automatic probe(input string tag, input int addr);
        load_word(0, 0, ins(OPC_ADD, addr, 0, 62));
        load_word(0, 1, ins(OPC_END, 0, 0, 0));
        run_check(tag, 1'b0);
    endtask

    task automatic random_prog(input string tag, input bit noise);
        int n, r, op;
        for (int i = 0; i < 4; i++) load_word(1, $urandom_range(1, 15), rnd_val());
        n = $urandom_range(1, 8);
        for (int i = 0; i < n - 1; i++) begin
            r  = $urandom_range(0, 19);
            op = (r < 2) ? OPC_NOP : (r < 7) ? OPC_ADD : (r < 12) ? OPC_SUB :
                 (r < 18) ? OPC_MUL : (r == 18) ? $urandom_range(4, 6) : OPC_END;
            load_word(0, i, ins(op, $urandom_range(1, 15), $urandom_range(1, 15),
                                $urandom_range(1, 15)));
        end
        load_word(0, n - 1, ins(OPC_END, 0, 0, 0));
        run_check(tag, noise);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge i_CLK);
        #1;
        check("reset.rdy", int'(o_RDY), 0);
        check("reset.error", int'(o_ERROR), 0);
        check("reset.result", int'(o_RESULT), 0);
        @(negedge i_CLK);
        i_RSTn = 1'b1;

        // Simple add
        load_word(1, 1, 5);
        load_word(1, 2, 7);
        load_word(0, 0, ins(OPC_ADD, 1, 2, 3));
        load_word(0, 1, ins(OPC_END, 0, 0, 0));
        run_check("add", 1'b0);
        check("add.const", int'($signed(o_RESULT)), 12);
        probe("add.dmem3", 3);

        // Multiply then subtract the freshly written value
        load_word(1, 1, 100);
        load_word(1, 2, -3);
        load_word(0, 0, ins(OPC_MUL, 1, 2, 4));
        load_word(0, 1, ins(OPC_SUB, 4, 1, 5));
        load_word(0, 2, ins(OPC_END, 0, 0, 0));
        run_check("mulsub", 1'b0);
        check("mulsub.const", int'($signed(o_RESULT)), -400);
        probe("mulsub.dmem5", 5);

        // Positive overflow: result and DMEM[3] unchanged
        load_word(1, 1, 32767);
        load_word(1, 2, 1);
        load_word(0, 0, ins(OPC_ADD, 1, 2, 3));
        load_word(0, 1, ins(OPC_END, 0, 0, 0));
        run_check("ovf", 1'b0);
        check("ovf.error", int'(o_ERROR), 1);
        probe("ovf.dmem3", 3);

        // Illegal opcode, then a clean program clears the error
        load_word(0, 0, ins(5, 1, 2, 3));
        run_check("illegal", 1'b0);
        check("illegal.error", int'(o_ERROR), 1);
        load_word(1, 7, -32768);
        load_word(1, 8, 1);
        load_word(0, 0, ins(OPC_ADD, 7, 8, 9));
        load_word(0, 1, ins(OPC_END, 0, 0, 0));
        run_check("recover", 1'b0);

        // Load strobes while busy must be ignored
        load_word(1, 1, 3);
        load_word(1, 2, 4);
        for (int i = 0; i < 8; i++) load_word(0, i, ins(OPC_ADD, 1, 2, 1));
        load_word(0, 8, ins(OPC_END, 0, 0, 0));
        run_check("noise", 1'b1);
        probe("noise.dmem1", 1);

        // Reset while executing a 10-instruction program
        load_word(1, 1, 2);
        for (int i = 0; i < 9; i++) load_word(0, i, ins(OPC_ADD, 1, 1, 1));
        load_word(0, 9, ins(OPC_END, 0, 0, 0));
        @(negedge i_CLK);
        i_WE = 1'b0;
        @(posedge i_CLK);
        repeat (5) @(posedge i_CLK);
        #2;
        i_RSTn = 1'b0;
        #1;
        check("midrst.rdy", int'(o_RDY), 0);
        check("midrst.error", int'(o_ERROR), 0);
        check("midrst.result", int'(o_RESULT), 0);
        model_reset();
        @(negedge i_CLK);
        i_RSTn = 1'b1;
        load_word(1, 1, -9);
        load_word(1, 2, 11);
        load_word(0, 0, ins(OPC_SUB, 1, 2, 3));
        load_word(0, 1, ins(OPC_MUL, 3, 2, 4));
        load_word(0, 2, ins(OPC_END, 0, 0, 0));
        run_check("reload", 1'b0);

        // Missing END: 63 NOPs plus the NOP at slot 63
        for (int i = 0; i < 63; i++) load_word(0, i, ins(OPC_NOP, 0, 0, 0));
        run_check("noend", 1'b0);
        check("noend.error", int'(o_ERROR), 1);

        // Randomized programs
        for (int t = 0; t < 30; t++) begin
            random_prog($sformatf("rand%0d", t), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
